dma_mem_rd_bp: RTL and testbench
================================

# dma_mem_rd_bp

Parametrised memory-to-AXI-Stream DMA read engine, successor to the fixed-latency read DMA used in the BRAM/URAM test harnesses. It drives one read port of a dual-port memory with configurable read LATENCY, applies an address stride with modulo-2^AW wrap, and streams words out on AXIS. An internal credit-managed skid FIFO guarantees full throughput and no data loss under arbitrary `m_axis_tready_i` backpressure.

## Interface
- `AW`, 12, memory address width; also the width of length and stride.
- `DW`, 144, data width.
- `LATENCY`, 1, memory read latency in cycles, legal range 1..8. Use 1 for registered BRAM and 5 for the URAM pipeline.
- `clk_i` in 1: the only clock.
- `rst_i` in 1: reset, **synchronous, active-high**.
- `dma_req_i` in 1: transfer request, four-phase.
- `dma_ack_o` out 1: transfer done / acknowledge.
- `dma_busy_o` out 1: high while the state is RUN.
- `dma_addr_i` in AW: start address, sampled on request.
- `dma_len_i` in AW: number of words to transfer; 0 means no transfer.
- `dma_stride_i` in AW: address increment per word; 0 means repeat the same address.
- `mem_en_o` out 1: memory read enable, one word per asserted cycle.
- `mem_addr_o` out AW: memory read address.
- `mem_dt_i` in DW: memory read data, valid LATENCY cycles after `mem_en_o`.
- `m_axis_tvalid_o` out 1: stream valid.
- `m_axis_tready_i` in 1: stream ready.
- `m_axis_tdata_o` out DW: stream data; forced to 0 when tvalid is 0.
- `m_axis_tlast_o` out 1: high on the final beat only.

## Operation
- **State machine** has three states: IDLE, RUN, ACK.
  - IDLE → RUN when `dma_req_i`=1 and `dma_len_i`≠0. On this edge latch addr, len and stride, and clear the issue and sent counters.
  - IDLE → ACK when `dma_req_i`=1 and `dma_len_i`=0. No memory access and no beats.
  - RUN → ACK on the edge where the last beat (sent = len-1) completes with tvalid&tready.
  - ACK → IDLE when `dma_req_i`=0.
- `dma_ack_o` is 1 exactly in ACK. `dma_busy_o` is 1 exactly in RUN.
- `dma_req_i` falling during RUN is ignored; there is no abort. The transfer always completes.
- **Issue rule.** In RUN, assert `mem_en_o` when issued < len and credits > 0.
  - credits = D − (in-flight + FIFO occupancy), where FIFO depth D = LATENCY+2.
  - On each issue: addr ← (addr + stride) mod 2^AW, and issued increments.
- **In-flight tracking.** A LATENCY-deep valid shift register tags issued reads. When the tag exits, `mem_dt_i` is written into the FIFO. Overflow is impossible by construction; verification asserts this.
- **AXIS output.**
  - tvalid = FIFO not empty; tdata = FIFO head.
  - Pop when tvalid&tready.
  - tlast = tvalid & (sent == len-1).
  - Sent counter increments per beat.
- Once asserted, tvalid and tdata stay stable until accepted, as AXIS requires.
- Counters are AW+1 bits wide, so len up to 2^AW−1 is legal.
- **Outputs outside an active issue cycle.** `mem_en_o`=0; `mem_addr_o` holds its last value.

## Timing
- Reset values: ack 0, busy 0, mem_en 0, mem_addr 0, tvalid 0, tdata 0, tlast 0. All counters, the FIFO pointers and the shift register are cleared; state is IDLE.
- Reset mid-transfer: in-flight data and FIFO contents are discarded. Returned memory data is ignored for the following LATENCY cycles because the tags are cleared.
- **First-beat latency**, with req sampled high at edge 0:
  - `mem_en_o` is high in cycle 1.
  - Data is captured into the FIFO at the end of cycle 1+LATENCY.
  - `m_axis_tvalid_o` is first high in cycle 2+LATENCY.
- With tready held 1, the stream delivers one beat per cycle with no bubbles, and the total transfer takes len+LATENCY+1 cycles from the first mem_en to the last beat.
- After backpressure releases, the first beat is presented in the same cycle; the refill keeps up because D = LATENCY+2.
- ACK is entered on the cycle after the last handshake. ack drops the cycle after req is seen low. The earliest next request is accepted 1 cycle after returning to IDLE.
- A req held continuously high does not start a second transfer. Re-arming requires passing through IDLE, which only happens with req=0.

## Test plan
- **Linear burst:** LATENCY=1, addr=0x010, len=8, stride=1, tready=1, memory word[n]=n → beats 0x10..0x17 on consecutive cycles; tlast on beat 8 only; mem_en pulses exactly 8 cycles; ack rises 1 cycle after the last beat.
- **URAM latency with backpressure:** LATENCY=5, len=16, stride=3, tready toggling with a 0/1/1/0 pattern → data matches addresses 3k mod 4096 in order; no drop or duplicate; in-flight+occupancy never exceeds 7; tvalid and tdata stable while stalled.
- **Wrap-around:** AW=12, addr=0xFFE, stride=1, len=4 → addresses 0xFFE, 0xFFF, 0x000, 0x001.
- **Zero length and stride:** len=0 → ack the cycle after req, with no mem_en and no tvalid. Then stride=0, len=3 → the same word three times, with tlast on the third.
- **Reset mid-transfer:** rst_i=1 for 1 cycle after 4 of 10 beats, with tready=0 so the FIFO is full → all outputs 0 the next cycle; no stale beats appear afterwards; a new len=2 transfer completes correctly.
- **Handshake:** req held high through ACK for 5 cycles → ack stays 1 and no second transfer starts; req dropped during RUN → the transfer still completes and ack is asserted.

Source files
------------

// File: rtl/dma_mem_rd_bp.sv
// Memory-to-AXIS read DMA: strided read issue, LATENCY-deep tag pipe, and a
// credit-managed skid FIFO that absorbs arbitrary stream backpressure.
module dma_mem_rd_bp #(
  parameter int AW      = 12,
  parameter int DW      = 144,
  parameter int LATENCY = 1
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          dma_req_i,
  output logic          dma_ack_o,
  output logic          dma_busy_o,
  input  logic [AW-1:0] dma_addr_i,
  input  logic [AW-1:0] dma_len_i,
  input  logic [AW-1:0] dma_stride_i,
  output logic          mem_en_o,
  output logic [AW-1:0] mem_addr_o,
  input  logic [DW-1:0] mem_dt_i,
  output logic          m_axis_tvalid_o,
  input  logic          m_axis_tready_i,
  output logic [DW-1:0] m_axis_tdata_o,
  output logic          m_axis_tlast_o
);
  localparam int D  = LATENCY + 2;
  localparam int PW = $clog2(D);
  localparam int CW = $clog2(D + 1);
  localparam int SW = 5;

  typedef enum logic [1:0] {IDLE, RUN, ACK} state_t;
  state_t state, state_nx;

  logic [AW-1:0] addr_q, stride_q, last_addr_q;
  logic [AW:0]   len_q, issued_q, sent_q;
  logic [LATENCY:1] tag_q;
  logic [LATENCY:0] vld_pipe;
  logic [DW-1:0] fifo_q [D];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic [SW-1:0] infl;
  logic          start, wr, pop, last_beat;

  // in-flight = tags already past the issue stage, including the one landing now
  always_comb begin
    infl = '0;
    for (int k = 1; k <= LATENCY; k++) infl = infl + SW'(tag_q[k]);
  end

  assign start     = (state == IDLE) && dma_req_i && (dma_len_i != '0);
  assign mem_en_o  = (state == RUN) && (issued_q < len_q) && ((infl + SW'(count)) < SW'(D));
  assign vld_pipe  = {tag_q, mem_en_o};
  assign wr        = vld_pipe[LATENCY];
  assign m_axis_tvalid_o = (count != '0);
  assign pop       = m_axis_tvalid_o && m_axis_tready_i;
  assign last_beat = (sent_q == len_q - 1'b1);
  assign m_axis_tlast_o  = m_axis_tvalid_o && last_beat;
  assign m_axis_tdata_o  = m_axis_tvalid_o ? fifo_q[rd_ptr] : '0;
  assign mem_addr_o = mem_en_o ? addr_q : last_addr_q;
  assign dma_ack_o  = (state == ACK);
  assign dma_busy_o = (state == RUN);

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (dma_req_i) state_nx = (dma_len_i == '0) ? ACK : RUN;
      RUN:  if (pop && last_beat) state_nx = ACK;
      ACK:  if (!dma_req_i) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= IDLE;
      addr_q      <= '0;
      stride_q    <= '0;
      last_addr_q <= '0;
      len_q       <= '0;
      issued_q    <= '0;
      sent_q      <= '0;
      tag_q       <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
    end else begin
      state <= state_nx;
      tag_q <= vld_pipe[LATENCY-1:0];
      if (start) begin
        addr_q   <= dma_addr_i;
        stride_q <= dma_stride_i;
        len_q    <= {1'b0, dma_len_i};
        issued_q <= '0;
        sent_q   <= '0;
      end else begin
        if (mem_en_o) begin
          addr_q      <= addr_q + stride_q;
          last_addr_q <= addr_q;
          issued_q    <= issued_q + 1'b1;
        end
        if (pop) sent_q <= sent_q + 1'b1;
      end
      if (wr) wr_ptr <= (wr_ptr == PW'(D - 1)) ? '0 : wr_ptr + 1'b1;
      if (pop) rd_ptr <= (rd_ptr == PW'(D - 1)) ? '0 : rd_ptr + 1'b1;
      case ({wr, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // storage needs no reset: pointers and count define what is live
  always_ff @(posedge clk_i) begin
    if (wr) fifo_q[wr_ptr] <= mem_dt_i;
  end
endmodule

// File: tb/tb_dma_mem_rd_bp.sv
// Bench: LATENCY=1 and LATENCY=5 instances share stimulus; a per-instance
// address/beat model checks every cycle, directed checks pin timing and data.
module tb_dma_mem_rd_bp;
  localparam int AW = 12;
  localparam int DW = 144;

  logic clk = 1'b0;
  logic rst, req, tready;
  logic [AW-1:0] addr, len, stride;
  logic ack [2];
  logic busy [2];
  logic en [2];
  logic tvalid [2];
  logic tlast [2];
  logic [AW-1:0] maddr [2];
  logic [DW-1:0] tdata [2];
  logic [DW-1:0] mdt [2];

  logic hist_en [2][8];
  logic [AW-1:0] hist_a [2][8];

  int n_tests, n_fail, cyc, xfer_id, seen_id, req_cyc;
  int issued_k [2];
  int beat_k [2];
  int first_en [2];
  int first_vld [2];
  int last_beat [2];
  int ack_rise [2];
  bit live [2];
  bit stall [2];
  logic [DW-1:0] sdata [2];
  logic [DW-1:0] first_data [2];
  logic [DW-1:0] last_data [2];
  logic [AW-1:0] alog [2][16];

  always #5 clk = ~clk;

  dma_mem_rd_bp #(.AW(AW), .DW(DW), .LATENCY(1)) u_l1 (
    .clk_i(clk), .rst_i(rst), .dma_req_i(req), .dma_ack_o(ack[0]), .dma_busy_o(busy[0]),
    .dma_addr_i(addr), .dma_len_i(len), .dma_stride_i(stride),
    .mem_en_o(en[0]), .mem_addr_o(maddr[0]), .mem_dt_i(mdt[0]),
    .m_axis_tvalid_o(tvalid[0]), .m_axis_tready_i(tready),
    .m_axis_tdata_o(tdata[0]), .m_axis_tlast_o(tlast[0]));

  dma_mem_rd_bp #(.AW(AW), .DW(DW), .LATENCY(5)) u_l5 (
    .clk_i(clk), .rst_i(rst), .dma_req_i(req), .dma_ack_o(ack[1]), .dma_busy_o(busy[1]),
    .dma_addr_i(addr), .dma_len_i(len), .dma_stride_i(stride),
    .mem_en_o(en[1]), .mem_addr_o(maddr[1]), .mem_dt_i(mdt[1]),
    .m_axis_tvalid_o(tvalid[1]), .m_axis_tready_i(tready),
    .m_axis_tdata_o(tdata[1]), .m_axis_tlast_o(tlast[1]));

  function automatic int lat(input int d);
    return (d == 0) ? 1 : 5;
  endfunction

  function automatic logic [AW-1:0] eaddr(input int k);
    int s;
    s = int'(addr) + k * int'(stride);
    return s[AW-1:0];
  endfunction

  function automatic bit pat(input int t);
    return (t % 4 == 1) || (t % 4 == 2);
  endfunction

  // memory: word[a] = a, returned LATENCY cycles after the enable; junk otherwise
  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        for (int k = 0; k < 8; k++) begin
          hist_en[d][k] <= 1'b0;
          hist_a[d][k]  <= '0;
        end
      end else begin
        hist_en[d][0] <= en[d];
        hist_a[d][0]  <= maddr[d];
        for (int k = 1; k < 8; k++) begin
          hist_en[d][k] <= hist_en[d][k-1];
          hist_a[d][k]  <= hist_a[d][k-1];
        end
      end
    end
  end
  assign mdt[0] = hist_en[0][0] ? DW'(hist_a[0][0]) : {DW{1'b1}};
  assign mdt[1] = hist_en[1][4] ? DW'(hist_a[1][4]) : {DW{1'b1}};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk_eq(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // per-cycle model compare
  always @(negedge clk) begin
    if (xfer_id != seen_id) begin
      seen_id = xfer_id;
      req_cyc = -1;
      for (int d = 0; d < 2; d++) begin
        issued_k[d] = 0; beat_k[d] = 0; first_en[d] = -1; first_vld[d] = -1;
        last_beat[d] = -1; ack_rise[d] = -1; live[d] = 1'b1;
      end
    end
    if (req && req_cyc < 0) req_cyc = cyc;
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        live[d] = 1'b0; stall[d] = 1'b0; issued_k[d] = 0; beat_k[d] = 0;
      end else begin
        if (en[d]) begin
          chk_eq("mem_en_allowed", DW'(live[d] && issued_k[d] < int'(len)), DW'(1));
          if (live[d] && issued_k[d] < int'(len))
            chk_eq("mem_addr", DW'(maddr[d]), DW'(eaddr(issued_k[d])));
          if (issued_k[d] < 16) alog[d][issued_k[d]] = maddr[d];
          if (first_en[d] < 0) first_en[d] = cyc;
          issued_k[d]++;
        end
        if (tvalid[d]) begin
          chk_eq("beat_allowed", DW'(live[d] && beat_k[d] < int'(len)), DW'(1));
          if (live[d] && beat_k[d] < int'(len)) begin
            chk_eq("tdata", tdata[d], DW'(eaddr(beat_k[d])));
            chk_eq("tlast", DW'(tlast[d]), DW'(beat_k[d] == int'(len) - 1));
          end
          if (stall[d]) chk_eq("tdata_stable", tdata[d], sdata[d]);
          if (first_vld[d] < 0) first_vld[d] = cyc;
          if (beat_k[d] == 0) first_data[d] = tdata[d];
          last_data[d] = tdata[d];
          if (tready) begin
            beat_k[d]++;
            last_beat[d] = cyc;
          end
        end else begin
          chk_eq("idle_tdata", tdata[d], DW'(0));
          chk_eq("idle_tlast", DW'(tlast[d]), DW'(0));
          if (stall[d]) chk_eq("tvalid_stable", DW'(tvalid[d]), DW'(1));
        end
        chk_eq("credit_bound", DW'(issued_k[d] - beat_k[d] <= lat(d) + 2), DW'(1));
        stall[d] = tvalid[d] && !tready;
        sdata[d] = tdata[d];
        if (ack[d] && ack_rise[d] < 0) ack_rise[d] = cyc;
      end
    end
  end

  task automatic chk_zero(input string nm);
    for (int d = 0; d < 2; d++) begin
      chk_eq({nm, "_ack"}, DW'(ack[d]), DW'(0));
      chk_eq({nm, "_busy"}, DW'(busy[d]), DW'(0));
      chk_eq({nm, "_en"}, DW'(en[d]), DW'(0));
      chk_eq({nm, "_addr"}, DW'(maddr[d]), DW'(0));
      chk_eq({nm, "_tvalid"}, DW'(tvalid[d]), DW'(0));
      chk_eq({nm, "_tdata"}, tdata[d], DW'(0));
      chk_eq({nm, "_tlast"}, DW'(tlast[d]), DW'(0));
    end
  endtask

  task automatic run_xfer(input logic [AW-1:0] a, input logic [AW-1:0] l, input logic [AW-1:0] s,
                          input int mode, input int hold, input bit drop);
    int t;
    addr = a; len = l; stride = s; tready = 1'b1;
    xfer_id++;
    req = 1'b1;
    step();
    if (drop) req = 1'b0;
    t = 0;
    while (!(ack_rise[0] >= 0 && ack_rise[1] >= 0) && t < 400) begin
      if (mode == 1) tready = pat(t);
      step();
      t++;
    end
    chk_eq("ack_timeout", DW'(t < 400), DW'(1));
    tready = 1'b1;
    for (int i = 0; i < hold; i++) begin
      for (int d = 0; d < 2; d++) begin
        chk_eq("ack_hold", DW'(ack[d]), DW'(1));
        chk_eq("busy_in_ack", DW'(busy[d]), DW'(0));
      end
      step();
    end
    req = 1'b0;
    t = 0;
    while ((ack[0] || ack[1]) && t < 10) begin
      step();
      t++;
    end
    chk_eq("ack_drop", DW'(ack[0] || ack[1]), DW'(0));
    step();
    for (int d = 0; d < 2; d++) begin
      chk_eq("en_count", DW'(issued_k[d]), DW'(int'(l)));
      chk_eq("beat_count", DW'(beat_k[d]), DW'(int'(l)));
      if (l == '0) begin
        chk_eq("zero_len_ack", DW'(ack_rise[d] - req_cyc), DW'(1));
      end else if (mode == 0) begin
        chk_eq("first_en_lat", DW'(first_en[d] - req_cyc), DW'(1));
        chk_eq("first_vld_lat", DW'(first_vld[d] - first_en[d]), DW'(1 + lat(d)));
        chk_eq("xfer_cycles", DW'(last_beat[d] - first_en[d]), DW'(int'(l) + lat(d)));
        chk_eq("ack_after_last", DW'(ack_rise[d] - last_beat[d]), DW'(1));
      end
    end
  endtask

  initial begin
    rst = 1'b1; req = 1'b0; tready = 1'b1;
    addr = '0; len = '0; stride = '0;
    repeat (3) step();
    @(negedge clk);
    chk_zero("reset");
    step();
    rst = 1'b0;
    step();

    // linear burst
    run_xfer(12'h010, 12'd8, 12'd1, 0, 0, 1'b0);
    for (int d = 0; d < 2; d++) begin
      chk_eq("burst_first", first_data[d], 144'h10);
      chk_eq("burst_last", last_data[d], 144'h17);
    end

    // stride 3 under 0/1/1/0 backpressure
    run_xfer(12'h000, 12'd16, 12'd3, 1, 0, 1'b0);
    chk_eq("stride3_addr5", DW'(alog[1][5]), DW'(12'd15));
    chk_eq("stride3_last", last_data[1], 144'd45);

    // wrap-around
    run_xfer(12'hFFE, 12'd4, 12'd1, 0, 0, 1'b0);
    for (int d = 0; d < 2; d++) begin
      chk_eq("wrap_a1", DW'(alog[d][1]), DW'(12'hFFF));
      chk_eq("wrap_a2", DW'(alog[d][2]), DW'(12'h000));
      chk_eq("wrap_a3", DW'(alog[d][3]), DW'(12'h001));
    end

    // zero length, then zero stride
    run_xfer(12'h123, 12'd0, 12'd1, 0, 0, 1'b0);
    run_xfer(12'h055, 12'd3, 12'd0, 0, 0, 1'b0);
    for (int d = 0; d < 2; d++) begin
      chk_eq("stride0_a2", DW'(alog[d][2]), DW'(12'h055));
      chk_eq("stride0_last", last_data[d], 144'h55);
    end

    // reset mid-transfer with full FIFOs
    addr = 12'h100; len = 12'd10; stride = 12'd1; tready = 1'b0;
    xfer_id++;
    req = 1'b1;
    step();
    req = 1'b0;
    repeat (20) step();
    tready = 1'b1;
    repeat (4) step();
    tready = 1'b0;
    for (int d = 0; d < 2; d++) chk_eq("pre_reset_beats", DW'(beat_k[d]), DW'(4));
    repeat (10) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    chk_zero("midreset");
    step();
    tready = 1'b1;
    repeat (20) step();
    run_xfer(12'h020, 12'd2, 12'd5, 0, 0, 1'b0);

    // req held through ACK, then req dropped during RUN
    run_xfer(12'h200, 12'd3, 12'd2, 0, 5, 1'b0);
    run_xfer(12'h300, 12'd6, 12'd7, 0, 0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
